// File: rtl/comparator_config_loader_pkg.sv
// Shared types and constants for the comparator configuration loader:
// FSM states, comparator targets, register map and per-target layout.
package comparator_config_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        T_PORT,
        T_IP,
        T_MAC,
        T_URL
    } target_t;

    localparam logic [3:0] ADDR_PORT   = 4'h0;
    localparam logic [3:0] ADDR_IP     = 4'h1;
    localparam logic [3:0] ADDR_MAC    = 4'h2;
    localparam logic [3:0] ADDR_URL    = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;
    localparam logic [3:0] ADDR_STATUS = 4'hD;

    localparam int STAGE_WORDS = 12;

    localparam int WORDS_PORT = 1;
    localparam int WORDS_IP   = 1;
    localparam int WORDS_MAC  = 2;
    localparam int WORDS_URL  = 8;

    function automatic logic [3:0] targetBase(input target_t t);
        case (t)
            T_PORT:  return ADDR_PORT;
            T_IP:    return ADDR_IP;
            T_MAC:   return ADDR_MAC;
            default: return ADDR_URL;
        endcase
    endfunction

    function automatic logic [2:0] targetLast(input target_t t);
        case (t)
            T_PORT:  return 3'(WORDS_PORT - 1);
            T_IP:    return 3'(WORDS_IP - 1);
            T_MAC:   return 3'(WORDS_MAC - 1);
            default: return 3'(WORDS_URL - 1);
        endcase
    endfunction

    // Lowest set bit wins, so targets always stream in port/ip/mac/url order.
    function automatic target_t lowestTarget(input logic [3:0] mask);
        casez (mask)
            4'b???1: return T_PORT;
            4'b??10: return T_IP;
            4'b?100: return T_MAC;
            4'b1000: return T_URL;
            default: return T_PORT;
        endcase
    endfunction

endpackage

// File: rtl/comparator_config_loader_staging.sv
// Twelve-word pattern staging file with Avalon write decode and a registered
// readback port; a second read port feeds the word currently being streamed.
module config_staging_regs
    import comparator_config_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_address,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_writeData,
    input  logic              i_read,
    input  logic              i_busy,
    input  logic [DATA_W-1:0] i_status,
    input  logic [3:0]        i_cfgIndex,
    output logic [DATA_W-1:0] o_readData,
    output logic [DATA_W-1:0] o_cfgData
);

    logic [DATA_W-1:0] r_stage [STAGE_WORDS];
    logic [DATA_W-1:0] r_readData;
    logic [DATA_W-1:0] w_readMux;
    logic              w_isStage;

    assign w_isStage = (i_address < 4'(STAGE_WORDS));

    always_comb begin
        w_readMux = '0;
        if (w_isStage) begin
            w_readMux = r_stage[i_address];
        end else if (i_address == ADDR_STATUS) begin
            w_readMux = i_status;
        end
    end

    // Staging is frozen while a commit streams it, so cfg_data cannot move mid-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGE_WORDS; i++) begin
                r_stage[i] <= '0;
            end
            r_readData <= '0;
        end else begin
            if (i_write && !i_busy && w_isStage) begin
                r_stage[i_address] <= i_writeData;
            end
            if (i_read && !i_write) begin
                r_readData <= w_readMux;
            end
        end
    end

    assign o_readData = r_readData;
    assign o_cfgData  = r_stage[i_cfgIndex];

endmodule

// File: rtl/comparator_config_loader.sv
// Avalon-MM slave that stages comparator patterns and, on commit, streams the
// selected targets word-by-word over the cfg valid/ready bus.
module comparator_config_loader
    import comparator_config_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        avs_address,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              cfg_valid,
    output logic [1:0]        cfg_sel,
    output logic [2:0]        cfg_word,
    output logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_ready,
    output logic              update_done,
    output logic              busy
);

    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    target_t     r_sel;
    logic [2:0]  r_word;
    logic [3:0]  r_mask;
    logic [7:0]  r_stall;
    logic [7:0]  r_commitCount;
    logic        r_timeoutErr;
    logic        r_dropErr;
    logic        r_busy;
    logic        r_cfgValid;
    logic        r_updateDone;

    logic              w_ctrlWrite;
    logic              w_statusWrite;
    logic              w_dropWrite;
    logic [3:0]        w_maskNext;
    logic [3:0]        w_cfgIndex;
    logic [DATA_W-1:0] w_status;

    assign w_ctrlWrite   = avs_write && !r_busy && (avs_address == ADDR_CTRL);
    assign w_statusWrite = avs_write && (avs_address == ADDR_STATUS);
    assign w_dropWrite   = avs_write && r_busy && (avs_address <= ADDR_CTRL);
    assign w_maskNext    = r_mask & ~(4'b0001 << r_sel);
    assign w_cfgIndex    = targetBase(r_sel) + {1'b0, r_word};
    assign w_status      = {{(DATA_W-16){1'b0}}, r_commitCount, 5'b0,
                            r_dropErr, r_timeoutErr, r_busy};

    config_staging_regs #(
        .DATA_W (DATA_W)
    ) u_staging (
        .clk         (clk),
        .rst         (rst),
        .i_address   (avs_address),
        .i_write     (avs_write),
        .i_writeData (avs_writedata),
        .i_read      (avs_read),
        .i_busy      (r_busy),
        .i_status    (w_status),
        .i_cfgIndex  (w_cfgIndex),
        .o_readData  (avs_readdata),
        .o_cfgData   (cfg_data)
    );

    // Error flags are set after the W1C clears so a simultaneous set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel         <= T_PORT;
            r_word        <= '0;
            r_mask        <= '0;
            r_stall       <= '0;
            r_commitCount <= '0;
            r_timeoutErr  <= 1'b0;
            r_dropErr     <= 1'b0;
            r_busy        <= 1'b0;
            r_cfgValid    <= 1'b0;
            r_updateDone  <= 1'b0;
        end else begin
            r_updateDone <= 1'b0;
            if (w_statusWrite) begin
                if (avs_writedata[1]) r_timeoutErr <= 1'b0;
                if (avs_writedata[2]) r_dropErr    <= 1'b0;
            end
            if (w_dropWrite) begin
                r_dropErr <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ctrlWrite) begin
                        r_busy <= 1'b1;
                        if (avs_writedata[3:0] != 4'b0) begin
                            r_mask     <= avs_writedata[3:0];
                            r_sel      <= lowestTarget(avs_writedata[3:0]);
                            r_word     <= '0;
                            r_stall    <= '0;
                            r_cfgValid <= 1'b1;
                            r_state    <= S_SEND;
                        end else begin
                            r_updateDone <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end

                S_SEND: begin
                    // A handshake takes priority over a stall expiring on the same edge.
                    if (cfg_ready) begin
                        r_stall <= '0;
                        if (r_word != targetLast(r_sel)) begin
                            r_word <= r_word + 3'd1;
                        end else begin
                            r_mask <= w_maskNext;
                            if (w_maskNext != 4'b0) begin
                                r_sel  <= lowestTarget(w_maskNext);
                                r_word <= '0;
                            end else begin
                                r_cfgValid   <= 1'b0;
                                r_updateDone <= 1'b1;
                                r_state      <= S_DONE;
                            end
                        end
                    end else if (r_stall == STALL_LIMIT) begin
                        r_cfgValid   <= 1'b0;
                        r_timeoutErr <= 1'b1;
                        r_mask       <= '0;
                        r_state      <= S_ABORT;
                    end else begin
                        r_stall <= r_stall + 8'd1;
                    end
                end

                S_DONE: begin
                    r_commitCount <= r_commitCount + 8'd1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_valid   = r_cfgValid;
    assign cfg_sel     = r_sel;
    assign cfg_word    = r_word;
    assign update_done = r_updateDone;
    assign busy        = r_busy;

endmodule

// File: tb/tb_comparator_config_loader.sv
// Scoreboard bench for comparator_config_loader: stimulus queues expected cfg
// words, a negedge monitor pops and compares them on every handshake.
module tb_comparator_config_loader;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  word;
        logic [31:0] data;
    } cfgTxn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        cfg_valid;
    logic [1:0]  cfg_sel;
    logic [2:0]  cfg_word;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        update_done;
    logic        busy;

    cfgTxn_t     sbQueue[$];
    cfgTxn_t     monExp;
    int          checks = 0;
    int          errors = 0;
    int          doneCount = 0;
    logic        prevDone = 1'b0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    comparator_config_loader #(
        .DATA_W  (32),
        .TIMEOUT (255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .cfg_valid     (cfg_valid),
        .cfg_sel       (cfg_sel),
        .cfg_word      (cfg_word),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .update_done   (update_done),
        .busy          (busy)
    );

    // Monitor: compares every accepted cfg word against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (update_done) begin
                doneCount++;
                checks++;
                if (prevDone) begin
                    errors++;
                    $display("[TB] FAIL donePulseWidth: update_done high 2 cycles, required 1");
                end
            end
            prevDone = update_done;
            if (cfg_valid && cfg_ready) begin
                checks++;
                if (sbQueue.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cfgUnexpected: got sel=%0d word=%0d data=%h, required no transfer",
                             cfg_sel, cfg_word, cfg_data);
                end else begin
                    monExp = sbQueue.pop_front();
                    if ({cfg_sel, cfg_word, cfg_data} !== monExp) begin
                        errors++;
                        $display("[TB] FAIL cfgWord: got sel=%0d word=%0d data=%h, required sel=%0d word=%0d data=%h",
                                 cfg_sel, cfg_word, cfg_data, monExp.sel, monExp.word, monExp.data);
                    end
                end
            end
        end else begin
            prevDone = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [1:0] s, input logic [2:0] w, input logic [31:0] d);
        sbQueue.push_back({s, w, d});
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (doneCount < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("doneReached", doneCount, target);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        avs_read = 1'b0; cfg_ready = 1'b0;
        tick(); tick();
        checkOutput("rstValid", cfg_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", update_done, 0);
        checkOutput("rstReaddata", avs_readdata, 0);
        rst = 1'b0;
        readReg(4'hD, rd);
        checkOutput("rstStatus", rd, 32'h0);

        $display("[TB] single port word commit");
        applyStimulus(4'h0, 32'h0000_0050);
        cfg_ready = 1'b1;
        pushExpected(2'd0, 3'd0, 32'h0000_0050);
        applyStimulus(4'hC, 32'h1);
        checkOutput("portValidLatency", cfg_valid, 1);
        tick();
        checkOutput("portDone", update_done, 1);
        checkOutput("portValidDrop", cfg_valid, 0);
        tick();
        checkOutput("portDoneOnce", update_done, 0);
        checkOutput("portIdle", busy, 0);
        readReg(4'hD, rd);
        checkOutput("portStatus", rd, 32'h0000_0100);

        $display("[TB] mac plus url commit");
        applyStimulus(4'h2, 32'h1111_2222);
        applyStimulus(4'h3, 32'h3333_4444);
        pushExpected(2'd2, 3'd0, 32'h1111_2222);
        pushExpected(2'd2, 3'd1, 32'h3333_4444);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'(4 + i), 32'hA000_0000 + 32'(i));
            pushExpected(2'd3, 3'(i), 32'hA000_0000 + 32'(i));
        end
        applyStimulus(4'hC, 32'hC);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("streamValid%0d", i), cfg_valid, 1);
            tick();
        end
        checkOutput("streamDone", update_done, 1);
        checkOutput("streamDrained", sbQueue.size(), 0);
        tick();
        readReg(4'hD, rd);
        checkOutput("streamStatus", rd, 32'h0000_0200);

        $display("[TB] stall timeout");
        cfg_ready = 1'b0;
        applyStimulus(4'hC, 32'h1);
        repeat (254) tick();
        checkOutput("stallStillValid", cfg_valid, 1);
        tick();
        checkOutput("abortValid", cfg_valid, 0);
        checkOutput("abortBusy", busy, 1);
        checkOutput("abortNoDone", update_done, 0);
        tick();
        checkOutput("abortIdle", busy, 0);
        readReg(4'hD, rd);
        checkOutput("abortStatus", rd, 32'h0000_0202);
        applyStimulus(4'hD, 32'h2);
        readReg(4'hD, rd);
        checkOutput("timeoutCleared", rd, 32'h0000_0200);
        checkOutput("abortDoneCount", doneCount, 2);

        $display("[TB] write while busy");
        applyStimulus(4'h1, 32'h1234_5678);
        cfg_ready = 1'b1;
        pushExpected(2'd1, 3'd0, 32'h1234_5678);
        for (int i = 0; i < 8; i++) pushExpected(2'd3, 3'(i), 32'hA000_0000 + 32'(i));
        applyStimulus(4'hC, 32'hA);
        applyStimulus(4'h1, 32'hDEAD_BEEF);
        waitDone(3, 40);
        checkOutput("dropDrained", sbQueue.size(), 0);
        readReg(4'h1, rd);
        checkOutput("dropStagingKept", rd, 32'h1234_5678);
        readReg(4'hD, rd);
        checkOutput("dropStatus", rd, 32'h0000_0304);
        applyStimulus(4'hD, 32'h4);
        readReg(4'hD, rd);
        checkOutput("dropCleared", rd, 32'h0000_0300);

        $display("[TB] empty mask commit");
        cfg_ready = 1'b1;
        applyStimulus(4'hC, 32'h0);
        checkOutput("emptyDone", update_done, 1);
        checkOutput("emptyNoValid", cfg_valid, 0);
        checkOutput("emptyBusy", busy, 1);
        tick();
        checkOutput("emptyDoneOnce", update_done, 0);
        checkOutput("emptyNoValid2", cfg_valid, 0);
        readReg(4'hD, rd);
        checkOutput("emptyStatus", rd, 32'h0000_0400);

        $display("[TB] reset mid url transfer");
        cfg_ready = 1'b0;
        for (int i = 0; i < 8; i++) pushExpected(2'd3, 3'(i), 32'hA000_0000 + 32'(i));
        applyStimulus(4'hC, 32'h8);
        for (int i = 0; i < 6; i++) begin
            cfg_ready = (i % 2 == 0);
            tick();
        end
        cfg_ready = 1'b0;
        checkOutput("midRemaining", sbQueue.size(), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRstValid", cfg_valid, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", update_done, 0);
        sbQueue.delete();
        tick(); tick();
        checkOutput("midNoDone", doneCount, 4);
        for (int i = 0; i < 12; i++) begin
            readReg(4'(i), rd);
            checkOutput($sformatf("midStage%0d", i), rd, 32'h0);
        end
        readReg(4'hD, rd);
        checkOutput("midStatus", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
